// File: rtl/set_assoc_atu_if.sv
// Bundled request/response, page-table-walker and invalidate channels of the ATU.
// "master" is the environment side (requester + walker); "slave" is the ATU.
interface set_assoc_atu_if #(
  parameter int VADDR_WIDTH = 64,
  parameter int PADDR_WIDTH = 64,
  parameter int ASID_WIDTH  = 8
);
  // Every channel: a transfer happens on the rising edge where valid && ready;
  // the sender holds valid and payload stable until that edge.
  logic                   req_valid;
  logic                   req_ready;
  logic [VADDR_WIDTH-1:0] req_vaddr;
  logic [ASID_WIDTH-1:0]  req_asid;

  logic                   resp_valid;
  logic                   resp_ready;
  logic [PADDR_WIDTH-1:0] resp_paddr;
  logic                   resp_hit;
  logic                   resp_fault;

  logic                   pt_rd_valid;
  logic                   pt_rd_ready;
  logic [VADDR_WIDTH-1:0] pt_rd_vaddr;
  logic [ASID_WIDTH-1:0]  pt_rd_asid;
  logic                   pt_rd_data_valid;
  logic [PADDR_WIDTH-1:0] pt_rd_paddr;
  logic                   pt_rd_fault;

  logic                   inv_valid;
  logic                   inv_ready;
  logic                   inv_all;
  logic [ASID_WIDTH-1:0]  inv_asid;
  logic                   inv_done;

  modport master (
    output req_valid, req_vaddr, req_asid, resp_ready,
           pt_rd_ready, pt_rd_data_valid, pt_rd_paddr, pt_rd_fault,
           inv_valid, inv_all, inv_asid,
    input  req_ready, resp_valid, resp_paddr, resp_hit, resp_fault,
           pt_rd_valid, pt_rd_vaddr, pt_rd_asid, inv_ready, inv_done
  );

  modport slave (
    input  req_valid, req_vaddr, req_asid, resp_ready,
           pt_rd_ready, pt_rd_data_valid, pt_rd_paddr, pt_rd_fault,
           inv_valid, inv_all, inv_asid,
    output req_ready, resp_valid, resp_paddr, resp_hit, resp_fault,
           pt_rd_valid, pt_rd_vaddr, pt_rd_asid, inv_ready, inv_done
  );
endinterface

// File: rtl/set_assoc_atu.sv
// Set-associative address translation unit: one outstanding translation, page-table
// walk on miss, per-set round-robin replacement, ASID-selective or full invalidate.
module set_assoc_atu #(
  parameter int VADDR_WIDTH       = 64,
  parameter int PADDR_WIDTH       = 64,
  parameter int PAGE_OFFSET_WIDTH = 12,
  parameter int NUM_SETS          = 64,
  parameter int NUM_WAYS          = 4,
  parameter int ASID_WIDTH        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  set_assoc_atu_if.slave      bus,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
  output logic [31:0]         fault_count,
  output logic [2:0]          dbg_state
);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int VPN_W = VADDR_WIDTH - PAGE_OFFSET_WIDTH;
  localparam int TAG_W = VPN_W - SET_W;
  localparam int PFN_W = PADDR_WIDTH - PAGE_OFFSET_WIDTH;

  typedef enum logic [2:0] {IDLE, LOOKUP, WALK_REQ, WALK_WAIT, RESPOND, INVAL} state_e;

  state_e                 state_q;
  logic [NUM_WAYS-1:0]    valid_q [NUM_SETS];
  logic [ASID_WIDTH-1:0]  asid_q  [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]       tag_q   [NUM_SETS][NUM_WAYS];
  logic [PFN_W-1:0]       pfn_q   [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]       rr_q    [NUM_SETS];
  logic [VADDR_WIDTH-1:0] vaddr_q;
  logic [ASID_WIDTH-1:0]  req_asid_q;
  logic [PADDR_WIDTH-1:0] paddr_q;
  logic                   hit_q;
  logic                   fault_q;
  logic                   inv_all_q;
  logic [ASID_WIDTH-1:0]  inv_asid_q;
  logic [SET_W-1:0]       inv_set_q;
  logic                   inv_done_q;
  logic [31:0]            hit_cnt_q;
  logic [31:0]            miss_cnt_q;
  logic [31:0]            fault_cnt_q;

  logic [VPN_W-1:0] vpn;
  logic [SET_W-1:0] set_idx;
  logic [TAG_W-1:0] tag;
  assign vpn     = vaddr_q[VADDR_WIDTH-1:PAGE_OFFSET_WIDTH];
  assign set_idx = vpn[SET_W-1:0];
  assign tag     = vpn[VPN_W-1:SET_W];

  // Hit detection and victim choice for the set of the registered request.
  logic             lk_hit;
  logic [PFN_W-1:0] lk_pfn;
  logic             free_found;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] rr_next;

  always_comb begin
    lk_hit     = 1'b0;
    lk_pfn     = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag && asid_q[set_idx][w] == req_asid_q) begin
        lk_hit = 1'b1;
        lk_pfn = pfn_q[set_idx][w];
      end
    end
  end

  assign victim  = free_found ? free_way : rr_q[set_idx];
  assign rr_next = (rr_q[set_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[set_idx] + WAY_W'(1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      vaddr_q     <= '0;
      req_asid_q  <= '0;
      paddr_q     <= '0;
      hit_q       <= 1'b0;
      fault_q     <= 1'b0;
      inv_all_q   <= 1'b0;
      inv_asid_q  <= '0;
      inv_set_q   <= '0;
      inv_done_q  <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      fault_cnt_q <= '0;
    end else begin
      inv_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.inv_valid) begin
            inv_all_q  <= bus.inv_all;
            inv_asid_q <= bus.inv_asid;
            inv_set_q  <= '0;
            state_q    <= INVAL;
          end else if (bus.req_valid) begin
            vaddr_q    <= bus.req_vaddr;
            req_asid_q <= bus.req_asid;
            state_q    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lk_hit) begin
            paddr_q   <= {lk_pfn, vaddr_q[PAGE_OFFSET_WIDTH-1:0]};
            hit_q     <= 1'b1;
            fault_q   <= 1'b0;
            hit_cnt_q <= sat_inc(hit_cnt_q);
            state_q   <= RESPOND;
          end else begin
            miss_cnt_q <= sat_inc(miss_cnt_q);
            state_q    <= WALK_REQ;
          end
        end
        WALK_REQ: if (bus.pt_rd_ready) state_q <= WALK_WAIT;
        WALK_WAIT: begin
          if (bus.pt_rd_data_valid) begin
            hit_q <= 1'b0;
            if (bus.pt_rd_fault) begin
              paddr_q     <= '0;
              fault_q     <= 1'b1;
              fault_cnt_q <= sat_inc(fault_cnt_q);
            end else begin
              paddr_q <= {bus.pt_rd_paddr[PADDR_WIDTH-1:PAGE_OFFSET_WIDTH],
                          vaddr_q[PAGE_OFFSET_WIDTH-1:0]};
              fault_q <= 1'b0;
              valid_q[set_idx][victim] <= 1'b1;
              tag_q[set_idx][victim]   <= tag;
              asid_q[set_idx][victim]  <= req_asid_q;
              pfn_q[set_idx][victim]   <= bus.pt_rd_paddr[PADDR_WIDTH-1:PAGE_OFFSET_WIDTH];
              // The pointer only advances when it actually chose the victim.
              if (!free_found) rr_q[set_idx] <= rr_next;
            end
            state_q <= RESPOND;
          end
        end
        RESPOND: if (bus.resp_ready) state_q <= IDLE;
        INVAL: begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            if (inv_all_q || asid_q[inv_set_q][w] == inv_asid_q) valid_q[inv_set_q][w] <= 1'b0;
          end
          if (inv_set_q == SET_W'(NUM_SETS - 1)) begin
            inv_done_q <= 1'b1;
            state_q    <= IDLE;
          end
          inv_set_q <= inv_set_q + SET_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // All outputs are forced low while reset is held, before the first reset edge too.
  logic resp_vld;
  logic walk_vld;
  assign resp_vld = rst_n && (state_q == RESPOND);
  assign walk_vld = rst_n && (state_q == WALK_REQ);

  assign bus.req_ready   = rst_n && (state_q == IDLE) && !bus.inv_valid;
  assign bus.inv_ready   = rst_n && (state_q == IDLE);
  assign bus.inv_done    = rst_n && inv_done_q;
  assign bus.resp_valid  = resp_vld;
  assign bus.resp_paddr  = resp_vld ? paddr_q : '0;
  assign bus.resp_hit    = resp_vld && hit_q;
  assign bus.resp_fault  = resp_vld && fault_q;
  assign bus.pt_rd_valid = walk_vld;
  assign bus.pt_rd_vaddr = walk_vld ? {vpn, {PAGE_OFFSET_WIDTH{1'b0}}} : '0;
  assign bus.pt_rd_asid  = walk_vld ? req_asid_q : '0;

  assign hit_count   = rst_n ? hit_cnt_q   : '0;
  assign miss_count  = rst_n ? miss_cnt_q  : '0;
  assign fault_count = rst_n ? fault_cnt_q : '0;
  assign dbg_state   = rst_n ? state_q     : 3'd0;

  logic unused_pt_offset;
  assign unused_pt_offset = ^bus.pt_rd_paddr[PAGE_OFFSET_WIDTH-1:0];
endmodule

// File: tb/tb_set_assoc_atu.sv
// Directed and randomized bench for set_assoc_atu against a translation-table model.
module tb_set_assoc_atu;
  localparam int NSETS = 64;
  localparam int NWAYS = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] hit_count, miss_count, fault_count;
  logic [2:0]  dbg_state;

  set_assoc_atu_if #(.VADDR_WIDTH(64), .PADDR_WIDTH(64), .ASID_WIDTH(8)) bus ();

  set_assoc_atu #(
    .VADDR_WIDTH(64), .PADDR_WIDTH(64), .PAGE_OFFSET_WIDTH(12),
    .NUM_SETS(NSETS), .NUM_WAYS(NWAYS), .ASID_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .hit_count(hit_count), .miss_count(miss_count), .fault_count(fault_count),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Translation-table model: page number, ASID and frame per way, plus replacement pointer.
  bit          m_valid [NSETS][NWAYS];
  logic [51:0] m_vpn   [NSETS][NWAYS];
  logic [7:0]  m_asid  [NSETS][NWAYS];
  logic [51:0] m_pfn   [NSETS][NWAYS];
  int          m_rr    [NSETS];
  int          exp_hits, exp_misses, exp_faults;

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NWAYS; w++) m_valid[s][w] = 0;
    end
    exp_hits = 0; exp_misses = 0; exp_faults = 0;
  endtask

  task automatic model_fill(input logic [51:0] vpn, input logic [7:0] asid, input logic [51:0] pfn);
    int s, v;
    s = int'(vpn % NSETS);
    v = -1;
    for (int w = NWAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % NWAYS;
    end
    m_valid[s][v] = 1; m_vpn[s][v] = vpn; m_asid[s][v] = asid; m_pfn[s][v] = pfn;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_counters();
    chk("hit_count", {32'd0, hit_count}, 64'(exp_hits));
    chk("miss_count", {32'd0, miss_count}, 64'(exp_misses));
    chk("fault_count", {32'd0, fault_count}, 64'(exp_faults));
  endtask

  // One complete translation, called and returning at a falling edge with the unit idle.
  task automatic do_req(input logic [63:0] va, input logic [7:0] asid, input logic [63:0] wpa,
                        input bit wf, input int pstall, input int rstall,
                        output logic [63:0] got_pa, output logic got_hit);
    logic [51:0] vpn;
    logic [63:0] epa;
    int s, n, eway;
    bit ehit;
    vpn = va[63:12];
    s = int'(vpn % NSETS);
    ehit = 0; eway = 0;
    for (int w = 0; w < NWAYS; w++)
      if (m_valid[s][w] && m_vpn[s][w] == vpn && m_asid[s][w] == asid) begin ehit = 1; eway = w; end

    bus.req_valid = 1; bus.req_vaddr = va; bus.req_asid = asid;
    n = 0;
    while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
    chk("req_accepted", 64'(n < 100), 64'd1);
    @(negedge clk);
    bus.req_valid = 0;
    chk("lookup_no_resp", 64'(bus.resp_valid), 64'd0);

    if (ehit) begin
      exp_hits++;
      epa = {m_pfn[s][eway], va[11:0]};
      @(negedge clk);
      chk("hit_latency_2", 64'(bus.resp_valid), 64'd1);
      chk("hit_no_walk", 64'(bus.pt_rd_valid), 64'd0);
    end else begin
      exp_misses++;
      n = 0;
      while (!bus.pt_rd_valid && n < 20) begin @(negedge clk); n++; end
      chk("walk_issued", 64'(bus.pt_rd_valid), 64'd1);
      chk("walk_vaddr", bus.pt_rd_vaddr, {va[63:12], 12'h000});
      chk("walk_asid", 64'(bus.pt_rd_asid), 64'(asid));
      for (int i = 0; i < pstall; i++) begin
        // A stray walker return before the request is taken must change nothing.
        bus.pt_rd_data_valid = (i == 0); bus.pt_rd_fault = 1; bus.pt_rd_paddr = '1;
        @(negedge clk);
        bus.pt_rd_data_valid = 0; bus.pt_rd_fault = 0;
        chk("walk_hold_valid", 64'(bus.pt_rd_valid), 64'd1);
        chk("walk_hold_vaddr", bus.pt_rd_vaddr, {va[63:12], 12'h000});
        chk("walk_hold_asid", 64'(bus.pt_rd_asid), 64'(asid));
        chk("walk_no_resp", 64'(bus.resp_valid), 64'd0);
      end
      bus.pt_rd_ready = 1;
      @(negedge clk);
      bus.pt_rd_ready = 0;
      chk("walk_taken", 64'(bus.pt_rd_valid), 64'd0);
      @(negedge clk);
      bus.pt_rd_data_valid = 1; bus.pt_rd_paddr = wpa; bus.pt_rd_fault = wf;
      @(negedge clk);
      bus.pt_rd_data_valid = 0; bus.pt_rd_fault = 0;
      if (wf) begin
        exp_faults++;
        epa = 64'd0;
      end else begin
        epa = {wpa[63:12], va[11:0]};
        model_fill(vpn, asid, wpa[63:12]);
      end
    end

    n = 0;
    while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
    chk("resp_seen", 64'(bus.resp_valid), 64'd1);
    got_pa = bus.resp_paddr;
    got_hit = bus.resp_hit;
    chk("resp_paddr", bus.resp_paddr, epa);
    chk("resp_hit", 64'(bus.resp_hit), 64'(ehit));
    chk("resp_fault", 64'(bus.resp_fault), 64'(!ehit && wf));
    for (int i = 0; i < rstall; i++) begin
      @(negedge clk);
      chk("resp_hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("resp_hold_paddr", bus.resp_paddr, epa);
      chk("resp_hold_hit", 64'(bus.resp_hit), 64'(ehit));
    end
    bus.resp_ready = 1;
    @(negedge clk);
    bus.resp_ready = 0;
    chk("resp_single", 64'(bus.resp_valid), 64'd0);
    chk("resp_zero_after", bus.resp_paddr, 64'd0);
    chk_counters();
  endtask

  task automatic do_inv(input bit all, input logic [7:0] asid);
    int n;
    bus.inv_valid = 1; bus.inv_all = all; bus.inv_asid = asid;
    n = 0;
    while (!bus.inv_ready && n < 100) begin @(negedge clk); n++; end
    chk("inv_accepted", 64'(n < 100), 64'd1);
    @(negedge clk);
    bus.inv_valid = 0; bus.req_valid = 0;
    n = 1;
    while (!bus.inv_done && n < NSETS + 20) begin
      chk("inv_busy_no_req", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      n++;
    end
    chk("inv_done_latency", 64'(n), 64'(NSETS + 1));
    @(negedge clk);
    chk("inv_done_pulse", 64'(bus.inv_done), 64'd0);
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < NWAYS; w++)
        if (all || m_asid[s][w] == asid) m_valid[s][w] = 0;
  endtask

  logic [63:0] pa, va, wpa, mc0;
  logic        hit;

  initial begin
    rst_n = 0;
    bus.req_valid = 0; bus.req_vaddr = '0; bus.req_asid = '0; bus.resp_ready = 0;
    bus.pt_rd_ready = 0; bus.pt_rd_data_valid = 0; bus.pt_rd_paddr = '0; bus.pt_rd_fault = 0;
    bus.inv_valid = 0; bus.inv_all = 0; bus.inv_asid = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_inv_ready", 64'(bus.inv_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_pt_rd_valid", 64'(bus.pt_rd_valid), 64'd0);
    chk_counters();
    rst_n = 1;
    @(negedge clk);
    chk("idle_req_ready", 64'(bus.req_ready), 64'd1);
    chk("idle_inv_ready", 64'(bus.inv_ready), 64'd1);

    // Cold miss, then the same page hits.
    do_req(64'h1234_5678, 8'd3, 64'hABCD_E000, 0, 0, 0, pa, hit);
    chk("cold_paddr", pa, 64'hABCD_E678);
    chk("cold_miss_count", {32'd0, miss_count}, 64'd1);
    do_req(64'h1234_5678, 8'd3, 64'h0, 0, 0, 0, pa, hit);
    chk("warm_hit", 64'(hit), 64'd1);
    chk("warm_paddr", pa, 64'hABCD_E678);
    chk("warm_hit_count", {32'd0, hit_count}, 64'd1);

    // ASID isolation.
    do_req(64'h5000, 8'd1, 64'h77_7000, 0, 0, 0, pa, hit);
    do_req(64'h5000, 8'd2, 64'h88_8000, 0, 0, 0, pa, hit);
    chk("asid2_miss", 64'(hit), 64'd0);

    // Five pages in set 0: the fifth fill evicts way 0 (the first page).
    for (int t = 1; t <= NWAYS + 1; t++)
      do_req(64'(t) << 18, 8'd5, 64'(t) << 24, 0, 0, 0, pa, hit);
    mc0 = {32'd0, miss_count};
    do_req(64'h1 << 18, 8'd5, 64'h1 << 24, 0, 0, 0, pa, hit);
    chk("evicted_first_misses", {32'd0, miss_count}, mc0 + 64'd1);

    // Walker fault, then a retry still misses.
    do_req(64'h9000_0123, 8'd4, 64'hDEAD_0000, 1, 0, 0, pa, hit);
    chk("fault_paddr", pa, 64'd0);
    chk("fault_count_1", {32'd0, fault_count}, 64'd1);
    do_req(64'h9000_0123, 8'd4, 64'hBEEF_0000, 0, 0, 0, pa, hit);
    chk("fault_retry_miss", 64'(hit), 64'd0);

    // Invalidate and request together: invalidate wins.
    bus.inv_valid = 1; bus.inv_all = 0; bus.inv_asid = 8'd1;
    bus.req_valid = 1; bus.req_vaddr = 64'h5000; bus.req_asid = 8'd2;
    #1;
    chk("both_req_ready", 64'(bus.req_ready), 64'd0);
    chk("both_inv_ready", 64'(bus.inv_ready), 64'd1);
    do_inv(0, 8'd1);
    chk_counters();
    do_req(64'h5000, 8'd1, 64'h77_7000, 0, 0, 0, pa, hit);
    chk("inv_asid1_miss", 64'(hit), 64'd0);
    do_req(64'h5000, 8'd2, 64'h0, 0, 0, 0, pa, hit);
    chk("inv_asid2_hit", 64'(hit), 64'd1);

    // Backpressure on both walker request and response.
    do_req(64'hA000_0ABC, 8'd6, 64'h1_2345_6000, 0, 3, 5, pa, hit);
    do_req(64'hA000_0DEF, 8'd6, 64'h0, 0, 0, 5, pa, hit);
    chk("bp_hit_paddr", pa, 64'h1_2345_6DEF);

    // Reset while waiting for walk data: operation abandoned.
    bus.req_valid = 1; bus.req_vaddr = 64'h7777_7000; bus.req_asid = 8'd7;
    @(negedge clk);
    bus.req_valid = 0;
    for (int i = 0; i < 10 && !bus.pt_rd_valid; i++) @(negedge clk);
    chk("rw_walk_issued", 64'(bus.pt_rd_valid), 64'd1);
    bus.pt_rd_ready = 1;
    @(negedge clk);
    bus.pt_rd_ready = 0;
    rst_n = 0;
    #1;
    chk("rw_rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rw_rst_inv_ready", 64'(bus.inv_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    bus.pt_rd_data_valid = 1; bus.pt_rd_paddr = 64'h4444_4000;
    @(negedge clk);
    bus.pt_rd_data_valid = 0;
    @(negedge clk);
    chk("rw_no_resp", 64'(bus.resp_valid), 64'd0);
    chk("rw_idle", 64'(bus.req_ready), 64'd1);
    chk_counters();
    do_req(64'h5000, 8'd2, 64'h99_9000, 0, 0, 0, pa, hit);
    chk("post_rst_miss", 64'(hit), 64'd0);

    // Random traffic over a few sets, tags and ASIDs.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        do_inv(1'($urandom_range(0, 1)), 8'($urandom_range(1, 3)));
      end else begin
        va  = (64'($urandom_range(0, 5)) << 18) | (64'($urandom_range(0, 2)) << 12)
              | 64'($urandom_range(0, 4095));
        wpa = {$urandom(), $urandom()};
        do_req(va, 8'($urandom_range(1, 3)), wpa, ($urandom_range(0, 7) == 0),
               $urandom_range(0, 2), $urandom_range(0, 2), pa, hit);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/set_assoc_atu.md
SET_ASSOC_ATU -- requirements
Module: set_assoc_atu

Interface
REQ-001 SHALL have parameter VADDR_WIDTH, default 64, virtual address width.
REQ-002 SHALL have parameter PADDR_WIDTH, default 64, physical address width.
REQ-003 SHALL have parameter PAGE_OFFSET_WIDTH, default 12, page offset bits (4 KiB pages).
REQ-004 SHALL have parameter NUM_SETS, default 64, TLB sets (power of two); SET_W = log2(NUM_SETS).
REQ-005 SHALL have parameter NUM_WAYS, default 4, ways per set (power of two, 1..8).
REQ-006 SHALL have parameter ASID_WIDTH, default 8, address-space ID width.
REQ-007 SHALL have ports: clk in 1 clock; rst_n in 1 reset. One clock; reset is synchronous and active-low.
REQ-008 SHALL have request ports: req_valid in 1; req_ready out 1; req_vaddr in VADDR_WIDTH; req_asid in ASID_WIDTH.
REQ-009 SHALL have response ports: resp_valid out 1; resp_ready in 1; resp_paddr out PADDR_WIDTH; resp_hit out 1 (TLB hit); resp_fault out 1 (walk reported fault).
REQ-010 SHALL have walker ports: pt_rd_valid out 1; pt_rd_ready in 1; pt_rd_vaddr out VADDR_WIDTH (page-aligned); pt_rd_asid out ASID_WIDTH; pt_rd_data_valid in 1; pt_rd_paddr in PADDR_WIDTH; pt_rd_fault in 1.
REQ-011 SHALL have invalidate ports: inv_valid in 1; inv_ready out 1; inv_all in 1 (1=flush all, 0=flush inv_asid); inv_asid in ASID_WIDTH; inv_done out 1 (one-cycle pulse).
REQ-012 SHALL have counter ports: hit_count out 32; miss_count out 32; fault_count out 32.

Function
REQ-013 SHALL store per entry: valid, asid, vpn tag (VADDR_WIDTH-PAGE_OFFSET_WIDTH-SET_W bits), pfn (PADDR_WIDTH-PAGE_OFFSET_WIDTH bits); set index = vpn[SET_W-1:0].
REQ-014 SHALL implement states IDLE, LOOKUP, WALK_REQ, WALK_WAIT, RESPOND, INVAL.
REQ-015 IDLE: inv_ready=1; req_ready=!inv_valid; inv_valid has priority over req_valid in the same cycle.
REQ-016 Request accepted on req_valid&&req_ready; vaddr and asid registered; go to LOOKUP.
REQ-017 LOOKUP (one cycle): hit = any way with valid, matching tag and matching asid; hit -> RESPOND with paddr={pfn, offset}, resp_hit=1, hit_count+1; miss -> WALK_REQ, miss_count+1.
REQ-018 Hit latency: resp_valid asserted exactly 2 cycles after the accepting edge.
REQ-019 WALK_REQ: pt_rd_valid=1, pt_rd_vaddr={vpn, zeros}, pt_rd_asid=registered asid, all held stable until pt_rd_ready; then WALK_WAIT.
REQ-020 WALK_WAIT: on pt_rd_data_valid&&!pt_rd_fault, fill the set, resp_paddr={pt_rd_paddr upper bits, offset}, resp_hit=0 -> RESPOND.
REQ-021 On pt_rd_data_valid&&pt_rd_fault: no fill, resp_paddr=0, resp_fault=1, fault_count+1 -> RESPOND.
REQ-022 Fill victim: lowest-index invalid way; if none, per-set round-robin pointer, which then increments modulo NUM_WAYS.
REQ-023 An identical vpn+asid is never duplicated across ways (the lookup missed, so no duplicate arises).
REQ-024 RESPOND: resp_valid=1 with paddr/hit/fault held stable until resp_ready; then IDLE; response outputs zero outside RESPOND.
REQ-025 INVAL: walks sets 0..NUM_SETS-1, one set per cycle, clearing valid on every way where inv_all or asid==registered inv_asid; takes exactly NUM_SETS cycles; inv_done pulses on the cycle after the last set; then IDLE.
REQ-026 Counters are 32-bit, saturate at 0xFFFFFFFF and never wrap.
REQ-027 pt_rd_data_valid outside WALK_WAIT SHALL be ignored.

Reset
REQ-028 While rst_n=0 at a clk edge: state=IDLE, all entry valid bits=0, all round-robin pointers=0, all counters=0.
REQ-029 While in reset, all outputs SHALL be 0, including req_ready and inv_ready.
REQ-030 Reset mid-walk or mid-invalidate SHALL abandon the operation with no fill, no response and no inv_done.

Verification
REQ-031 Cold miss: vaddr 0x1234_5678, asid 3, walker returns 0xABCD_E000 -> resp_paddr 0xABCD_E678, hit=0, miss_count=1; repeat -> hit=1 at 2-cycle latency, hit_count=1.
REQ-032 ASID isolation: fill vaddr 0x5000 under asid 1; look up 0x5000 under asid 2 -> miss and walk issued.
REQ-033 Replacement: NUM_WAYS+1 distinct vpns mapping to set 0 -> fifth fill evicts way 0; the first vpn then misses.
REQ-034 Fault: walker returns pt_rd_fault=1 -> resp_fault=1, paddr 0; a retry still misses; fault_count=1.
REQ-035 Invalidate: entries under asid 1 and 2; inv_all=0, inv_asid=1 -> inv_done after NUM_SETS+1 cycles; asid 1 misses, asid 2 hits; inv_valid and req_valid asserted together -> invalidate served first.
REQ-036 Backpressure: resp_ready=0 for 5 cycles and pt_rd_ready=0 for 3 cycles -> outputs held stable, no lost or duplicate response; reset asserted during WALK_WAIT -> IDLE, counters 0.
